// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the multi-cycle ALU.
package alu_pkg;

  // Base opcodes keep the single-cycle ALU encoding; M opcodes set bit 4.
  typedef enum logic [4:0] {
    ALU_ADD    = 5'b00000,
    ALU_SLL    = 5'b00001,
    ALU_SLT    = 5'b00010,
    ALU_SLTU   = 5'b00011,
    ALU_XOR    = 5'b00100,
    ALU_SRL    = 5'b00101,
    ALU_OR     = 5'b00110,
    ALU_AND    = 5'b00111,
    ALU_SUB    = 5'b01000,
    ALU_SRA    = 5'b01101,
    ALU_MUL    = 5'b10000,
    ALU_MULH   = 5'b10001,
    ALU_MULHSU = 5'b10010,
    ALU_MULHU  = 5'b10011,
    ALU_DIV    = 5'b10100,
    ALU_DIVU   = 5'b10101,
    ALU_REM    = 5'b10110,
    ALU_REMU   = 5'b10111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  // M ops occupy 10xxx; 11xxx is unused and treated as a single-cycle zero.
  function automatic logic is_m_op(input logic [4:0] op);
    return (op[4:3] == 2'b10);
  endfunction

endpackage

// File: rtl/alu_base.sv
// Combinational evaluator for the single-cycle (base) ALU operations.
// Any opcode that is not a base op yields zero.
module alu_base
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       op,
  output logic [WIDTH-1:0] res
);

  logic [SHW-1:0] shamt;

  assign shamt = b[SHW-1:0];

  // Decode the opcode and compute the result; unknown codes give zero.
  always_comb begin
    res = '0;
    case (op)
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_XOR:  res = a ^ b;
      ALU_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SLL:  res = a << shamt;
      ALU_SRL:  res = a >> shamt;
      ALU_SRA:  res = $unsigned($signed(a) >>> shamt);
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: base ops in one registered cycle, RV32M multiply/divide
// iteratively over WIDTH cycles using one shared 2*WIDTH accumulator.
//
// Handshake: an op is accepted on a cycle where in_valid & in_ready; a result
// is consumed on a cycle where out_valid & out_ready. out_valid holds, with
// ALURes stable, until consumed; only flush or rst may withdraw it.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALURes
);

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  state_e             state, state_nxt;
  logic [SHW-1:0]     cnt;
  logic [4:0]         op_r;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic               neg_q;
  logic               neg_r;

  logic               accept;
  logic               last;
  logic [WIDTH-1:0]   base_res;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               neg_q_in;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_nxt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   fin;

  alu_base #(.WIDTH(WIDTH), .SHW(SHW)) u_base (
    .a   (A),
    .b   (B),
    .op  (ALUOp),
    .res (base_res)
  );

  assign in_ready  = ((state == IDLE) | ((state == DONE) & out_ready)) & ~flush & ~rst;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign last      = (cnt == CNT_LAST);

  // Reduce incoming operands to magnitudes and decide the final sign fix.
  // A zero divisor never negates the all-ones quotient.
  always_comb begin
    sign_a   = A[WIDTH-1] & (ALUOp inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM});
    sign_b   = B[WIDTH-1] & (ALUOp inside {ALU_MULH, ALU_DIV, ALU_REM});
    mag_a    = sign_a ? -A : A;
    mag_b    = sign_b ? -B : B;
    neg_q_in = (sign_a ^ sign_b) & (~ALUOp[2] | (B != '0));
  end

  // One shift-add multiply step and one restoring-divide step, plus the
  // sign-fixed result that is registered on the final iteration.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    mul_nxt   = {mul_sum, acc[WIDTH-1:1]};
    div_trial = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = {1'b0, div_trial} - {2'b00, opb};
    div_ge    = ~div_diff[WIDTH+1];
    div_nxt   = {(div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                 acc[WIDTH-2:0], div_ge};
    prod      = neg_q ? -mul_nxt : mul_nxt;
    quo       = div_nxt[WIDTH-1:0];
    rem       = div_nxt[2*WIDTH-1:WIDTH];
    fin       = '0;
    case (op_r)
      ALU_MUL:                          fin = prod[WIDTH-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU:  fin = prod[2*WIDTH-1:WIDTH];
      ALU_DIV, ALU_DIVU:                fin = neg_q ? -quo : quo;
      ALU_REM, ALU_REMU:                fin = neg_r ? -rem : rem;
      default:                          fin = '0;
    endcase
  end

  // Next-state logic; flush forces IDLE from any state.
  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (is_m_op(ALUOp)) state_nxt = ALUOp[2] ? DIV : MUL;
      else                state_nxt = DONE;
    end else begin
      case (state)
        MUL:     if (last) state_nxt = DONE;
        DIV:     if (last) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
    if (flush) state_nxt = IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand capture, iteration and result register; ALURes only moves on
  // entry to DONE (or on reset).
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      op_r   <= '0;
      acc    <= '0;
      opb    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      ALURes <= '0;
    end else if (!flush) begin
      if (accept) begin
        op_r <= ALUOp;
        cnt  <= '0;
        if (is_m_op(ALUOp)) begin
          acc   <= {{WIDTH{1'b0}}, mag_a};
          opb   <= mag_b;
          neg_q <= neg_q_in;
          neg_r <= sign_a;
        end else begin
          ALURes <= base_res;
        end
      end else if (state == MUL) begin
        acc <= mul_nxt;
        cnt <= cnt + SHW'(1);
        if (last) ALURes <= fin;
      end else if (state == DIV) begin
        acc <= div_nxt;
        cnt <= cnt + SHW'(1);
        if (last) ALURes <= fin;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32) with an expected-result queue.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic [4:0]   alu_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_res;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rnd_rdy = 1'b0;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           acc_q[$];

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .ALUOp     (alu_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALURes    (alu_res)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // reference model
  function automatic logic [W-1:0] ref_alu(input logic [4:0] op, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    int          sx, sy;
    longint      lx, ly, luy;
    logic [63:0] p;
    logic [4:0]  sh;
    sx  = x;
    sy  = y;
    lx  = sx;
    ly  = sy;
    luy = longint'({32'h0, y});
    sh  = y[4:0];
    case (op)
      ALU_ADD:  return x + y;
      ALU_SUB:  return x - y;
      ALU_AND:  return x & y;
      ALU_OR:   return x | y;
      ALU_XOR:  return x ^ y;
      ALU_SLT:  return (sx < sy) ? 32'd1 : 32'd0;
      ALU_SLTU: return (x < y) ? 32'd1 : 32'd0;
      ALU_SLL:  return x << sh;
      ALU_SRL:  return x >> sh;
      ALU_SRA:  return 32'(sx >>> sh);
      ALU_MUL:    begin p = 64'(lx * ly);  return p[31:0];  end
      ALU_MULH:   begin p = 64'(lx * ly);  return p[63:32]; end
      ALU_MULHSU: begin p = 64'(lx * luy); return p[63:32]; end
      ALU_MULHU:  begin p = {32'h0, x} * {32'h0, y}; return p[63:32]; end
      ALU_DIV: begin
        if (y == 0) return '1;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        return 32'(sx / sy);
      end
      ALU_DIVU: return (y == 0) ? '1 : x / y;
      ALU_REM: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return '0;
        return 32'(sx % sy);
      end
      ALU_REMU: return (y == 0) ? x : x % y;
      default:  return '0;
    endcase
  endfunction

  // driver: present an op at a negedge, wait for acceptance, push expectation
  task automatic issue(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit must_ready);
    int n;
    alu_op   = op;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    #1;
    if (must_ready) check("in_ready_immediate", in_ready, 1);
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(ref_alu(op, x, y));
    lat_q.push_back(is_m_op(op) ? W + 1 : 1);
    acc_q.push_back(cyc);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    #1;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("wait_valid", out_valid, 1);
  endtask

  // random backpressure
  always @(negedge clk) if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));

  // scoreboard monitor
  logic         prev_v = 1'b0;
  logic         prev_hs = 1'b0;
  logic [W-1:0] cur_exp = '0;
  always @(negedge clk) begin
    #2;
    if (rst) begin
      prev_v  = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (out_valid) begin
        if (!prev_v || prev_hs) begin
          if (exp_q.size() == 0) begin
            check("unexpected_valid", out_valid, 0);
          end else begin
            cur_exp = exp_q[0];
            check("result", alu_res, cur_exp);
            check("latency", 64'(cyc - acc_q[0]), 64'(lat_q[0]));
          end
        end else begin
          check("held_result", alu_res, cur_exp);
        end
        if (out_ready && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          void'(lat_q.pop_front());
          void'(acc_q.pop_front());
        end
      end
      prev_v  = out_valid;
      prev_hs = out_valid & out_ready;
    end
  end

  logic [4:0] op_tab [20];

  initial begin
    op_tab = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU, ALU_SLL,
               ALU_SRL, ALU_SRA, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV,
               ALU_DIVU, ALU_REM, ALU_REMU, 5'b01001, 5'b11000};
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a         = 32'h1234;
    b         = 32'h5678;
    alu_op    = ALU_ADD;

    // reset with in_valid held high
    repeat (3) begin
      @(negedge clk);
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_alures", alu_res, 0);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);
    @(negedge clk);

    // base ops back to back
    issue(ALU_ADD, 32'd5, 32'd7, 1'b1);
    issue(ALU_SRA, 32'h8000_0000, 32'd4, 1'b1);
    issue(ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 1'b1);
    issue(ALU_SUB, 32'd3, 32'd10, 1'b1);
    issue(ALU_SLT, 32'hFFFF_FFFF, 32'd0, 1'b1);
    drain();

    // multiply
    issue(ALU_MULH, 32'hFFFF_FFFF, 32'd2, 1'b0);
    issue(ALU_MULHU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    issue(ALU_MUL, 32'hFFFF_FFFF, 32'd2, 1'b0);
    issue(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    // divide corner cases
    issue(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    issue(ALU_REM, 32'hFFFF_FFF9, 32'd2, 1'b0);
    issue(ALU_DIVU, 32'd9, 32'd0, 1'b0);
    issue(ALU_REMU, 32'd9, 32'd0, 1'b0);
    issue(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(ALU_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0);
    issue(ALU_REM, 32'hFFFF_FFF9, 32'd0, 1'b0);
    drain();

    // backpressure on a DIVU result with a waiting op
    out_ready = 1'b0;
    issue(ALU_DIVU, 32'd100, 32'd7, 1'b0);
    wait_valid();
    alu_op   = ALU_ADD;
    a        = 32'd3;
    b        = 32'd4;
    in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      #1;
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_alures", alu_res, 32'd14);
    end
    @(negedge clk);
    out_ready = 1'b1;
    issue(ALU_ADD, 32'd3, 32'd4, 1'b1);
    drain();

    // flush an in-flight MUL
    issue(ALU_MUL, 32'd123, 32'd456, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_state", dut.state, IDLE);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready_after", in_ready, 1);
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    void'(acc_q.pop_back());
    repeat (40) @(negedge clk);
    check("flush_no_valid", out_valid, 0);
    issue(ALU_ADD, 32'd1, 32'd1, 1'b1);
    drain();

    // random ops with random consumer backpressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] x, y;
      x = $urandom();
      y = $urandom();
      case ($urandom_range(0, 5))
        0: y = '0;
        1: y = 32'hFFFF_FFFF;
        2: x = 32'h8000_0000;
        3: y = 32'($urandom_range(1, 40));
        default: ;
      endcase
      issue(op_tab[$urandom_range(0, 19)], x, y, 1'b0);
    end
    rnd_rdy = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    drain();

    // reset in the middle of a multiply clears the result register
    issue(ALU_MUL, 32'd3, 32'd5, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midop_rst_alures", alu_res, 0);
    check("midop_rst_out_valid", out_valid, 0);
    exp_q.delete();
    lat_q.delete();
    acc_q.delete();
    rst = 1'b0;
    @(negedge clk);
    issue(ALU_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1);
    drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle datapath ALU.
- Executes all base ALU operations in one registered cycle, and RV32M multiply/divide/remainder iteratively over WIDTH cycles.
- Uses a valid/ready handshake on both input and output, so the core can stall on long ops.
- Sits between the register-read stage and write-back of the next-generation (multi-cycle) core.

Parameters:
- WIDTH, 32: operand/result width; must be a power of two, 8 to 64.
- SHW, $clog2(WIDTH): shift-amount width (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  abort any in-flight op; result discarded
- in_valid  in  1  operands/op valid
- in_ready  out  1  block can accept an op this cycle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- ALUOp  in  5  operation code (see Behaviour)
- out_valid  out  1  ALURes holds a finished result
- out_ready  in  1  consumer takes result this cycle
- ALURes  out  WIDTH  result

Behaviour:
- Clocking and reset: one clock (clk), reset synchronous active-high (rst).
- On rst: state=IDLE, out_valid=0, ALURes=0, counter=0, operand/accumulator regs=0.
- in_ready is combinational: (state==IDLE | (state==DONE & out_ready)) & !flush & !rst.
- Accept occurs when in_valid & in_ready. A, B and ALUOp are captured on accept and need not be held afterwards.
- Base opcodes (ALUOp[4]=0), identical encoding to the single-cycle ALU:
  - 0000 ADD, 1000 SUB, 0111 AND, 0110 OR, 0100 XOR
  - 0010 SLT (signed), 0011 SLTU
  - 0001 SLL, 0101 SRL, 1101 SRA; shift amount is B[SHW-1:0]
- M opcodes:
  - 10000 MUL (low WIDTH bits), 10001 MULH (s×s high), 10010 MULHSU (s×u high), 10011 MULHU (u×u high)
  - 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU
- Any other code: ALURes=0, single-cycle latency. No latch, no X.
- States:
  - IDLE: on accept of a base op -> DONE, result registered.
  - IDLE: on accept of an M op -> MUL or DIV. Operands converted to magnitudes, sign flags stored, counter=0.
  - MUL: shift-add, one bit per cycle, 2·WIDTH-bit accumulator. After counter==WIDTH-1 -> DONE, with sign fix applied in the DONE-entry cycle.
  - DIV: restoring division, one quotient bit per cycle. After counter==WIDTH-1 -> DONE, with sign fix applied.
  - DONE: out_valid=1, ALURes stable until out_ready.
    - out_ready & !in_valid -> IDLE.
    - out_ready & in_valid -> accept the new op (back-to-back).
- Latency, accept cycle N:
  - Base op: out_valid asserted at cycle N+1.
  - M op: out_valid asserted at cycle N+WIDTH+1.
  - Throughput: 1 base op/cycle when out_ready is held high.
- Result sign rules:
  - DIV/REM: quotient negative iff signs differ; remainder takes the dividend's sign.
  - MULH: product negated iff signs differ; MULHSU uses A's sign only.
- Divide by zero: quotient = all ones; remainder = A. Still takes the full WIDTH+1 cycles, so latency is uniform.
- Signed overflow (A=most-negative, B=-1): DIV gives A, REM gives 0.
- flush:
  - Any state -> IDLE next cycle; out_valid=0 next cycle. Any in-flight or unconsumed result is dropped.
  - No accept is possible in the flush cycle.
- rst mid-operation: same as flush, plus ALURes clears to 0.
- out_valid never drops without out_ready, except on flush/rst.
- ALURes changes only on the DONE-entry edge, or on rst.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [4:0] alu_op_e, covering all 18 opcodes above
  - typedef enum state_e {IDLE, MUL, DIV, DONE}
  - function is_m_op
- Sub-module alu_base: purely combinational base-op evaluator (WIDTH-parametrised). It is instantiated once and registered by alu_mc.
- The iterative mul/div datapath stays in alu_mc, sharing one 2·WIDTH accumulator and one counter.

Test Plan:
- Reset and idle: hold rst 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, ALURes=0; one cycle after release, in_ready=1.
- Base ops back-to-back, out_ready=1: ADD 5+7, then SRA 0x80000000>>>4, then SLTU 1<0xFFFFFFFF -> results 12, 0xF8000000, 1 on consecutive cycles N+1..N+3; in_ready stays 1.
- Multiply, WIDTH=32: MULH 0xFFFFFFFF×2 -> 0xFFFFFFFF; MULHU same operands -> 0x00000001; MUL -> 0xFFFFFFFE; out_valid exactly 33 cycles after accept.
- Divide corner cases: DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; DIVU 9/0 -> 0xFFFFFFFF, REMU 9/0 -> 9; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
- Backpressure: hold out_ready=0 for 10 cycles after a DIVU 100/7 result -> ALURes stays 14 and out_valid stays 1; in_ready=0 throughout; on out_ready=1, a simultaneous new op is accepted in that same cycle.
- Flush: issue MUL, assert flush at cycle 10 -> out_valid never rises for it, state is IDLE next cycle, in_ready=1 one cycle after flush. Then ADD 1+1 -> 2 at accept+1.
